// File: rtl/operand_pkg.sv
// Shared types and helpers for the operand entry stage: one-hot FSM states,
// default operand width and the debounce counter sizing function.
package operand_pkg;

    localparam int DATA_W_DEF = 4;

    // Encodings double as the LEDR[2:0] pattern {PRESENT, GET_B, GET_A}.
    typedef enum logic [2:0] {
        GET_A   = 3'b001,
        GET_B   = 3'b010,
        PRESENT = 3'b100
    } state_t;

    function automatic int debounce_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises one active-low raw key, debounces it and produces a one-cycle
// pulse on every accepted press (1->0 of the accepted level).
module key_debounce
    import operand_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
)
(
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = debounce_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Reset to the released level so a key held through reset is seen as a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    // The counter only runs while the synced level disagrees with the accepted one,
    // so any bounce back to the accepted level restarts the stability window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt + 1'b1 == CNT_LIMIT) begin
                cnt   <= '0;
                level <= sync2;
                press <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_sequencer.sv
// Collects operand A, operand B and the add/subtract mode from the board keys and
// switches, then offers them downstream under a valid/ack handshake.
module operand_sequencer
    import operand_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DATA_W          = DATA_W_DEF
)
(
    input  logic              MAX10_CLK1_50,
    input  logic              RST,
    input  logic [DATA_W-1:0] SW,
    input  logic              KEY_ENTER_N,
    input  logic              KEY_MODE_N,
    input  logic              op_ack,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              sub,
    output logic              op_valid,
    output logic [2:0]        state_led
);

    logic [DATA_W-1:0] sw_meta;
    logic [DATA_W-1:0] sw_sync;
    logic              enter_level_unused;
    logic              enter_pulse;
    logic              mode_level;
    logic              mode_press_unused;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] a_next;
    logic [DATA_W-1:0] b_next;
    logic              sub_next;

    always_ff @(posedge MAX10_CLK1_50 or posedge RST) begin
        if (RST) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= SW;
            sw_sync <= sw_meta;
        end
    end

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk     (MAX10_CLK1_50),
        .rst     (RST),
        .key_raw (KEY_ENTER_N),
        .level   (enter_level_unused),
        .press   (enter_pulse)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk     (MAX10_CLK1_50),
        .rst     (RST),
        .key_raw (KEY_MODE_N),
        .level   (mode_level),
        .press   (mode_press_unused)
    );

    // A press arriving in PRESENT is dropped, even when it coincides with the ack.
    always_comb begin
        state_next = state;
        a_next     = op_a;
        b_next     = op_b;
        sub_next   = sub;
        unique case (state)
            GET_A: begin
                if (enter_pulse) begin
                    a_next     = sw_sync;
                    state_next = GET_B;
                end
            end
            GET_B: begin
                if (enter_pulse) begin
                    b_next     = sw_sync;
                    sub_next   = ~mode_level;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (op_ack) begin
                    state_next = GET_A;
                end
            end
            default: state_next = GET_A;
        endcase
    end

    always_ff @(posedge MAX10_CLK1_50 or posedge RST) begin
        if (RST) begin
            state    <= GET_A;
            op_a     <= '0;
            op_b     <= '0;
            sub      <= 1'b0;
            op_valid <= 1'b0;
        end else begin
            state    <= state_next;
            op_a     <= a_next;
            op_b     <= b_next;
            sub      <= sub_next;
            op_valid <= (state_next == PRESENT);
        end
    end

    assign state_led = state;

endmodule
